alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 18-bit single-cycle ALU used in the datapath.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_iter_unit.sv | 95 +++++++++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states, flag bit positions.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift / shift-add multiply datapath; one bit per step, owner drives start/step.
// Latency: shifts take k steps, multiply takes WIDTH steps; done flags the final step.
// Backpressure: none; the owning FSM only steps while busy. Multiplier exists only with ALU_MUL_EN.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         src,
    input  logic [$clog2(WIDTH)-1:0] amt,
`ifdef ALU_MUL_EN
    input  logic [WIDTH-1:0]         mplr,
`endif
    output logic                     done,
    output logic [WIDTH-1:0]         res,
    output logic                     cout
);

    localparam int SHW = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for multiply as well as any shift amount.
    localparam int CW  = SHW + 1;

    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             is_shr;
    logic [WIDTH-1:0] nxt_work;
    logic             nxt_last;

`ifdef ALU_MUL_EN
    logic             is_mul;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   psum;
    logic [WIDTH-1:0] nxt_hi;
`endif

    // Working register: load operands on start, advance one bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            is_shr <= 1'b0;
`ifdef ALU_MUL_EN
            is_mul <= 1'b0;
            hi     <= '0;
            mcand  <= '0;
`endif
        end else if (start) begin
            work   <= src;
            cnt    <= {1'b0, amt};
            is_shr <= (op == ALU_SHR);
`ifdef ALU_MUL_EN
            is_mul <= (op == ALU_MUL);
            hi     <= '0;
            mcand  <= src;
            if (op == ALU_MUL) begin
                work <= mplr;
                cnt  <= CW'(WIDTH);
            end
`endif
        end else if (step && (cnt != '0)) begin
            work <= nxt_work;
            cnt  <= cnt - CW'(1);
`ifdef ALU_MUL_EN
            hi   <= nxt_hi;
`endif
        end
    end

    // Next-step value; the owner captures it directly on the final step, so the
    // bit shifted out last never needs its own register.
    always_comb begin
        nxt_work = is_shr ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
        nxt_last = is_shr ? work[0] : work[WIDTH-1];
        cout     = nxt_last;
`ifdef ALU_MUL_EN
        addend = work[0] ? {1'b0, mcand} : '0;
        psum   = {1'b0, hi} + addend;
        nxt_hi = psum[WIDTH:1];
        if (is_mul) begin
            nxt_work = {psum[0], work[WIDTH-1:1]};
            cout     = |nxt_hi;
        end
`endif
        res  = nxt_work;
        done = (cnt == CW'(1));
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU (ADD/SUB/OR/AND/XOR/SHL/SHR/MUL) with Z/N/C/V flags; ALU_MUL_EN enables the multiplier.
// Latency: 1 cycle for logic/arith and zero shifts, k+1 for shifts by k, WIDTH+1 for multiply.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so at most one op per 2 cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             use_iter;
    logic             busy;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_cout;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] imm_res;
    logic             imm_c;
    logic             imm_v;
    logic [3:0]       flg;

    // Shifts by a nonzero amount (and multiply, when built) go through the iterative unit.
    always_comb begin
        use_iter = is_shift(op) && (b[SHW-1:0] != '0);
`ifdef ALU_MUL_EN
        if (op == ALU_MUL) begin
            use_iter = 1'b1;
        end
`endif
    end

    // Single-cycle result and carry/overflow; shifts by zero pass A through unchanged.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        imm_res = '0;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        case (op)
            ALU_ADD: begin
                imm_res = sum[WIDTH-1:0];
                imm_c   = sum[WIDTH];
                imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                imm_res = diff[WIDTH-1:0];
                imm_c   = diff[WIDTH];
                imm_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OR:  imm_res = a | b;
            ALU_AND: imm_res = a & b;
            ALU_XOR: imm_res = a ^ b;
            ALU_SHL,
            ALU_SHR: imm_res = a;
            default: imm_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == S_IDLE) && !rst;
        out_valid = (state == S_DONE);
        accept    = in_valid && in_ready;
        busy      = (state == S_BUSY);
        case (state)
            S_IDLE: if (accept) state_nxt = use_iter ? S_BUSY : S_DONE;
            S_BUSY: if (iter_done) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign iter_start = accept && use_iter;

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (iter_start),
        .step  (busy),
        .op    (op),
        .src   (a),
        .amt   (b[SHW-1:0]),
`ifdef ALU_MUL_EN
        .mplr  (b),
`endif
        .done  (iter_done),
        .res   (iter_res),
        .cout  (iter_cout)
    );

    // Output registers: load on a single-cycle accept or on the final iterative step, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flg    <= '0;
        end else if (accept && !use_iter) begin
            result       <= imm_res;
            flg[FLG_Z]   <= (imm_res == '0);
            flg[FLG_N]   <= imm_res[WIDTH-1];
            flg[FLG_C]   <= imm_c;
            flg[FLG_V]   <= imm_v;
        end else if (busy && iter_done) begin
            result       <= iter_res;
            flg[FLG_Z]   <= (iter_res == '0);
            flg[FLG_N]   <= iter_res[WIDTH-1];
            flg[FLG_C]   <= iter_cout;
            flg[FLG_V]   <= 1'b0;
        end
    end

    assign z = flg[FLG_Z];
    assign n = flg[FLG_N];
    assign c = flg[FLG_C];
    assign v = flg[FLG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=18): directed vector table, handshake corner sequences, random ops vs model.
// Latency: measured in cycles from the accepting edge to the first cycle with out_valid.
// Backpressure: exercised with held out_ready and a pending input during DONE.
module tb_alu_seq;

    localparam int W = 18;
    localparam longint unsigned MOD  = 64'd1 << W;
    localparam longint unsigned HALF = 64'd1 << (W - 1);
    localparam longint unsigned MASK = MOD - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         z;
    logic         n;
    logic         c;
    logic         v;

    int n_checks   = 0;
    int n_err      = 0;
    int stable_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v)
    );

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0] flg;   // {z,n,c,v}
        int         lat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [W-1:0] r, input logic [3:0] f, input int l);
        vec_t e;
        e.name = nm; e.op = o; e.a = ia; e.b = ib; e.res = r; e.flg = f; e.lat = l;
        vq.push_back(e);
    endtask

    function automatic longint to_s(input longint unsigned x);
        return (x >= HALF) ? longint'(x) - longint'(MOD) : longint'(x);
    endfunction

    // Reference: results straight from the arithmetic definitions of each op.
    task automatic model(input logic [2:0] o, input longint unsigned ia, input longint unsigned ib,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat);
        longint unsigned rr;
        longint unsigned p;
        longint          s;
        int              k;
        logic            cc;
        logic            vv;
        rr = 0; cc = 0; vv = 0; lat = 1;
        k  = int'(ib % 32);
        case (o)
            3'd0: begin
                rr = (ia + ib) & MASK; cc = ((ia + ib) >= MOD);
                s = to_s(ia) + to_s(ib); vv = (s < -longint'(HALF)) || (s >= longint'(HALF));
            end
            3'd1: begin
                rr = (ia + MOD - ib) & MASK; cc = (ia < ib);
                s = to_s(ia) - to_s(ib); vv = (s < -longint'(HALF)) || (s >= longint'(HALF));
            end
            3'd2: rr = ia | ib;
            3'd3: rr = ia & ib;
            3'd4: rr = ia ^ ib;
            3'd5: begin
                rr  = (k >= W) ? 0 : ((ia << k) & MASK);
                cc  = (k == 0) ? 1'b0 : (k <= W) ? 1'((ia >> (W - k)) & 1) : 1'b0;
                lat = k + 1;
            end
            3'd6: begin
                rr  = ia >> k;
                cc  = (k == 0) ? 1'b0 : 1'((ia >> (k - 1)) & 1);
                lat = k + 1;
            end
            default: begin
`ifdef ALU_MUL_EN
                p   = ia * ib;
                rr  = p & MASK;
                cc  = ((p >> W) != 0);
                lat = W + 1;
`else
                p   = 0;
                rr  = p;
`endif
            end
        endcase
        r = W'(rr);
        f = {(rr == 0), r[W-1], cc, vv};
    endtask

    // Issue one op, wait for its result, optionally stall the consumer for `hold` cycles.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib, input int hold,
                          output logic [W-1:0] r, output logic [3:0] f, output int lat, output int busy_rdy);
        int w;
        @(negedge clk);
        op = o; a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w == 100) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        busy_rdy = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy++;
            @(negedge clk);
            lat++;
        end
        r = result;
        f = {z, n, c, v};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (result !== r || {z, n, c, v} !== f || out_valid !== 1'b1) stable_bad++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] er;
        logic [3:0]   f;
        logic [3:0]   ef;
        int           lat;
        int           elat;
        int           brdy;
        int           stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {z, n, c, v}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        add_vec("add_wrap",   3'd0, 18'h3FFFF, 18'h00001, 18'h00000, 4'b1010, 1);
        add_vec("sub_borrow", 3'd1, 18'h00005, 18'h00007, 18'h3FFFE, 4'b0110, 1);
        add_vec("add_ovf",    3'd0, 18'h1FFFF, 18'h00001, 18'h20000, 4'b0101, 1);
        add_vec("sub_ovf",    3'd1, 18'h20000, 18'h00001, 18'h1FFFF, 4'b0001, 1);
        add_vec("or",         3'd2, 18'h20000, 18'h00001, 18'h20001, 4'b0100, 1);
        add_vec("and_zero",   3'd3, 18'h3FFFF, 18'h00000, 18'h00000, 4'b1000, 1);
        add_vec("xor",        3'd4, 18'h0F0F0, 18'h0FFFF, 18'h00F0F, 4'b0000, 1);
        add_vec("shl_17",     3'd5, 18'h00001, 18'h00011, 18'h20000, 4'b0100, 18);
        add_vec("shr_1",      3'd6, 18'h00003, 18'h00001, 18'h00001, 4'b0010, 2);
        add_vec("shl_0",      3'd5, 18'h00005, 18'h00000, 18'h00005, 4'b0000, 1);
        add_vec("shl_width",  3'd5, 18'h00003, 18'h00012, 18'h00000, 4'b1010, 19);
        add_vec("shr_31",     3'd6, 18'h3FFFF, 18'h0001F, 18'h00000, 4'b1000, 32);
`ifdef ALU_MUL_EN
        add_vec("mul",        3'd7, 18'd300,   18'd1000,  18'h093E0, 4'b0010, 19);
`else
        add_vec("mul_off",    3'd7, 18'd300,   18'd1000,  18'h00000, 4'b1000, 1);
`endif

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, 0, r, f, lat, brdy);
            chk({vq[i].name, "_result"}, r, vq[i].res);
            chk({vq[i].name, "_flags"}, f, vq[i].flg);
            chk({vq[i].name, "_latency"}, lat, vq[i].lat);
            if (vq[i].lat > 1) chk({vq[i].name, "_busy_in_ready"}, brdy, 0);
            chk({vq[i].name, "_valid_drop"}, out_valid, 0);
        end

        // Backpressure with a new op already presented while the result is stalled.
        @(negedge clk);
        op = 3'd4; a = 18'h0F0F0; b = 18'h0FFFF; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 op = 3'd0; a = 18'h00001; b = 18'h00001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 18'h00F0F);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_take_in_ready", in_ready, 1);
        chk("bp_after_take_valid", out_valid, 0);
        chk("bp_after_take_result", result, 18'h00F0F);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, 18'h00002);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the fourth busy cycle of a 10-bit shift.
        @(negedge clk);
        op = 3'd5; a = 18'h00001; b = 18'h0000A; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {z, n, c, v}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("postrst_no_stale", stale, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 250; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int           sel;
            ro  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            ra  = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? 18'h20000 : W'($urandom);
            sel = $urandom_range(0, 5);
            rb  = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? 18'h1FFFF : W'($urandom);
            model(ro, longint'(ra), longint'(rb), er, ef, elat);
            run_op(ro, ra, rb, $urandom_range(0, 2), r, f, lat, brdy);
            chk($sformatf("rnd%0d_op%0d_result", i, ro), r, er);
            chk($sformatf("rnd%0d_op%0d_flags", i, ro), f, ef);
            chk($sformatf("rnd%0d_op%0d_latency", i, ro), lat, elat);
        end
        chk("rnd_hold_stable", stable_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
